// File: rtl/dmem_arbiter_pkg.sv
// =====================================================================
// dmem_arb_pkg: shared types and default widths for the dmem arbiter.
// Rev 1.0
// =====================================================================
`default_nettype none

package dmem_arb_pkg;

  localparam int c_ADDR_W_DEF = 12;
  localparam int c_DATA_W_DEF = 32;

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    LOCK_L = 1'b1
  } arb_state_e;

  typedef enum logic [0:0] {
    OWN_P = 1'b0,
    OWN_L = 1'b1
  } owner_e;

endpackage

`default_nettype wire

// File: rtl/dmem_arbiter_if.sv
// =====================================================================
// dmem_arbiter_if: requester handshakes plus the dmem-side bus.
// Rev 1.0
// =====================================================================
`default_nettype none

interface dmem_arbiter_if
  import dmem_arb_pkg::*;
#(
  parameter int ADDR_W = c_ADDR_W_DEF,
  parameter int DATA_W = c_DATA_W_DEF
);

  logic              p_req;
  logic              p_wren;
  logic [ADDR_W-1:0] p_addr;
  logic [DATA_W-1:0] p_wdata;
  logic              p_gnt;
  logic              p_rvalid;

  logic              l_req;
  logic              l_wren;
  logic              l_lock;
  logic [ADDR_W-1:0] l_addr;
  logic [DATA_W-1:0] l_wdata;
  logic              l_gnt;
  logic              l_rvalid;

  logic [DATA_W-1:0] rdata;
  logic [ADDR_W-1:0] address_dmem;
  logic [DATA_W-1:0] data;
  logic              wren;
  logic [DATA_W-1:0] q_dmem;

  modport slave (
    input  p_req, p_wren, p_addr, p_wdata,
    input  l_req, l_wren, l_lock, l_addr, l_wdata,
    input  q_dmem,
    output p_gnt, p_rvalid, l_gnt, l_rvalid,
    output rdata, address_dmem, data, wren
  );

  modport master (
    output p_req, p_wren, p_addr, p_wdata,
    output l_req, l_wren, l_lock, l_addr, l_wdata,
    output q_dmem,
    input  p_gnt, p_rvalid, l_gnt, l_rvalid,
    input  rdata, address_dmem, data, wren
  );

endinterface

`default_nettype wire

// File: rtl/dmem_arbiter_sat_counter.sv
// =====================================================================
// sat_counter: up-counter saturating at LIMIT, clear has priority.
// Rev 1.0
// =====================================================================
`default_nettype none

module sat_counter #(
  parameter int WIDTH = 4,
  parameter int LIMIT = 15
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             inc_i,
  input  logic             clr_i,
  output logic [WIDTH-1:0] count_o,
  output logic             at_limit_o
);

  localparam logic [WIDTH-1:0] c_LIMIT = WIDTH'(LIMIT);

  logic [WIDTH-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (inc_i && (count_q != c_LIMIT)) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o    = count_q;
  assign at_limit_o = (count_q == c_LIMIT);

endmodule

`default_nettype wire

// File: rtl/dmem_arbiter.sv
// =====================================================================
// dmem_arbiter: processor/loader arbiter for single-port dmem, locked
// loader bursts. DMEM_ARB_RR_EN selects round robin over fixed priority.
// =====================================================================
`default_nettype none

module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int ADDR_W    = c_ADDR_W_DEF,
  parameter int DATA_W    = c_DATA_W_DEF,
  parameter int MAX_WAIT  = 4,
  parameter int MAX_BURST = 16
) (
  input  logic          clock,
  input  logic          reset,
  dmem_arbiter_if.slave bus
);

  localparam int                   c_BURST_W    = $clog2(MAX_BURST + 1);
  localparam logic [c_BURST_W-1:0] c_BURST_LAST = c_BURST_W'(MAX_BURST - 1);

  arb_state_e        state_q, state_d;
  logic              prefer_p_q, prefer_p_d;
  logic              rd_valid_q, rd_valid_d;
  owner_e            owner_q, owner_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              wren_mux;
  logic              grant_p, grant_l;

  logic                 burst_inc, burst_clr, burst_at_limit;
  logic [c_BURST_W-1:0] burst_cnt;

  sat_counter #(.WIDTH(c_BURST_W), .LIMIT(MAX_BURST)) u_burst_cnt (
    .clock      (clock),
    .reset      (reset),
    .inc_i      (burst_inc),
    .clr_i      (burst_clr),
    .count_o    (burst_cnt),
    .at_limit_o (burst_at_limit)
  );

`ifdef DMEM_ARB_RR_EN
  owner_e last_winner_q, last_winner_d;

  always_comb begin
    last_winner_d = last_winner_q;
    if (grant_l) begin
      last_winner_d = OWN_L;
    end else if (grant_p) begin
      last_winner_d = OWN_P;
    end
  end

  // Resetting to loader hands the first conflict to the processor.
  always_ff @(posedge clock) begin
    if (reset) begin
      last_winner_q <= OWN_L;
    end else begin
      last_winner_q <= last_winner_d;
    end
  end
`else
  localparam int c_WAIT_W = $clog2(MAX_WAIT + 1);

  logic                wait_at_limit;
  logic [c_WAIT_W-1:0] unused_wait_cnt;

  sat_counter #(.WIDTH(c_WAIT_W), .LIMIT(MAX_WAIT)) u_wait_cnt (
    .clock      (clock),
    .reset      (reset),
    .inc_i      (bus.l_req & ~grant_l),
    .clr_i      (grant_l),
    .count_o    (unused_wait_cnt),
    .at_limit_o (wait_at_limit)
  );
`endif

  always_comb begin
    state_d    = state_q;
    prefer_p_d = 1'b0;
    grant_p    = 1'b0;
    grant_l    = 1'b0;
    burst_inc  = 1'b0;
    burst_clr  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.p_req && bus.l_req) begin
          if (prefer_p_q) begin
            grant_p = 1'b1;
`ifdef DMEM_ARB_RR_EN
          end else if (last_winner_q == OWN_L) begin
            grant_p = 1'b1;
          end else begin
            grant_l = 1'b1;
          end
`else
          end else if (wait_at_limit) begin
            grant_l = 1'b1;
          end else begin
            grant_p = 1'b1;
          end
`endif
        end else begin
          grant_p = bus.p_req;
          grant_l = bus.l_req;
        end
        if (grant_l && bus.l_lock && (MAX_BURST > 1)) begin
          state_d   = LOCK_L;
          burst_inc = 1'b1;
        end else begin
          burst_clr = 1'b1;
        end
      end
      LOCK_L: begin
        // The at-limit guard is unreachable: the last beat always exits.
        grant_l   = bus.l_req && !burst_at_limit;
        burst_inc = grant_l;
        if (!grant_l || !bus.l_lock || (burst_cnt == c_BURST_LAST)) begin
          state_d    = IDLE;
          prefer_p_d = 1'b1;
          burst_clr  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    if (reset) begin
      grant_p = 1'b0;
      grant_l = 1'b0;
    end
  end

  // Hold registers track the mux so an ungranted cycle replays the last beat.
  always_comb begin
    addr_d   = addr_q;
    data_d   = data_q;
    wren_mux = 1'b0;
    if (grant_p) begin
      addr_d   = bus.p_addr;
      data_d   = bus.p_wdata;
      wren_mux = bus.p_wren;
    end else if (grant_l) begin
      addr_d   = bus.l_addr;
      data_d   = bus.l_wdata;
      wren_mux = bus.l_wren;
    end
  end

  always_comb begin
    rd_valid_d = (grant_p & ~bus.p_wren) | (grant_l & ~bus.l_wren);
    owner_d    = owner_q;
    if (rd_valid_d) begin
      owner_d = grant_l ? OWN_L : OWN_P;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= IDLE;
      prefer_p_q <= 1'b0;
      rd_valid_q <= 1'b0;
      owner_q    <= OWN_P;
      addr_q     <= '0;
      data_q     <= '0;
    end else begin
      state_q    <= state_d;
      prefer_p_q <= prefer_p_d;
      rd_valid_q <= rd_valid_d;
      owner_q    <= owner_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
    end
  end

  assign bus.p_gnt        = grant_p;
  assign bus.l_gnt        = grant_l;
  assign bus.address_dmem = addr_d;
  assign bus.data         = data_d;
  assign bus.wren         = wren_mux;
  assign bus.rdata        = bus.q_dmem;
  assign bus.p_rvalid     = rd_valid_q & (owner_q == OWN_P) & ~reset;
  assign bus.l_rvalid     = rd_valid_q & (owner_q == OWN_L) & ~reset;

endmodule

`default_nettype wire

// File: tb/tb_dmem_arbiter.sv
// =====================================================================
// tb_dmem_arbiter: directed self-checking bench with a 1-cycle dmem model.
// Rev 1.0
// =====================================================================
`default_nettype none

module tb_dmem_arbiter;

  logic clock;
  logic reset;

  dmem_arbiter_if #(.ADDR_W(12), .DATA_W(32)) bus ();

  dmem_arbiter #(
    .ADDR_W    (12),
    .DATA_W    (32),
    .MAX_WAIT  (4),
    .MAX_BURST (16)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  logic [31:0] mem [0:4095];

  always @(posedge clock) begin
    if (bus.wren) mem[bus.address_dmem] <= bus.data;
    bus.q_dmem <= mem[bus.address_dmem];
  end

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic clear_inputs();
    bus.p_req   = 1'b0;
    bus.p_wren  = 1'b0;
    bus.p_addr  = '0;
    bus.p_wdata = '0;
    bus.l_req   = 1'b0;
    bus.l_wren  = 1'b0;
    bus.l_lock  = 1'b0;
    bus.l_addr  = '0;
    bus.l_wdata = '0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  logic [11:0] pre_addr [4];
  logic [31:0] pre_data [4];
  logic [1:0]  exp_gnt;

  initial begin
    pre_addr = '{12'h010, 12'h001, 12'h002, 12'h003};
    pre_data = '{32'hDEADBEEF, 32'h11111111, 32'h22222222, 32'h33333333};

    // Reset with both requests up: nothing may be granted or written
    clear_inputs();
    reset = 1'b1;
    bus.p_req  = 1'b1;
    bus.l_req  = 1'b1;
    bus.p_wren = 1'b1;
    bus.l_wren = 1'b1;
    #2;
    check_eq("rst_gnt", {bus.p_gnt, bus.l_gnt}, 2'b00);
    check_eq("rst_wren", bus.wren, 1'b0);
    tick();
    check_eq("rst_addr", bus.address_dmem, 12'h000);
    check_eq("rst_data", bus.data, 32'h0);
    check_eq("rst_rvalid", {bus.p_rvalid, bus.l_rvalid}, 2'b00);
    clear_inputs();
    tick();
    reset = 1'b0;

    // Preload through processor writes
    for (int i = 0; i < 4; i++) begin
      bus.p_req   = 1'b1;
      bus.p_wren  = 1'b1;
      bus.p_addr  = pre_addr[i];
      bus.p_wdata = pre_data[i];
      tick();
    end
    clear_inputs();

    // Read return
    bus.p_req  = 1'b1;
    bus.p_addr = 12'h010;
    #1;
    check_eq("rd_gnt", {bus.p_gnt, bus.l_gnt}, 2'b10);
    tick();
    clear_inputs();
    #1;
    check_eq("rd_rvalid", {bus.p_rvalid, bus.l_rvalid}, 2'b10);
    check_eq("rd_data", bus.rdata, 32'hDEADBEEF);
    tick();

    // Alternating reads P@1, L@2, P@3
    bus.p_req  = 1'b1;
    bus.p_addr = 12'h001;
    tick();
    clear_inputs();
    bus.l_req  = 1'b1;
    bus.l_addr = 12'h002;
    #1;
    check_eq("alt1_rvalid", {bus.p_rvalid, bus.l_rvalid}, 2'b10);
    check_eq("alt1_data", bus.rdata, 32'h11111111);
    tick();
    clear_inputs();
    bus.p_req  = 1'b1;
    bus.p_addr = 12'h003;
    #1;
    check_eq("alt2_rvalid", {bus.p_rvalid, bus.l_rvalid}, 2'b01);
    check_eq("alt2_data", bus.rdata, 32'h22222222);
    tick();
    clear_inputs();
    #1;
    check_eq("alt3_rvalid", {bus.p_rvalid, bus.l_rvalid}, 2'b10);
    check_eq("alt3_data", bus.rdata, 32'h33333333);
    tick();

    // Sustained conflict from a fresh reset
    do_reset();
    bus.p_req = 1'b1;
    bus.l_req = 1'b1;
    for (int i = 0; i < 10; i++) begin
`ifdef DMEM_ARB_RR_EN
      exp_gnt = (i % 2 == 1) ? 2'b01 : 2'b10;
`else
      exp_gnt = (i % 5 == 4) ? 2'b01 : 2'b10;
`endif
      #1;
      check_eq($sformatf("conflict_%0d", i), {bus.p_gnt, bus.l_gnt}, exp_gnt);
      tick();
    end
    clear_inputs();

    // Locked burst of writes; processor joins after the first beat
    bus.l_req   = 1'b1;
    bus.l_lock  = 1'b1;
    bus.l_wren  = 1'b1;
    bus.l_addr  = 12'h100;
    bus.l_wdata = 32'd0;
    #1;
    check_eq("burst_beat_0", {bus.p_gnt, bus.l_gnt}, 2'b01);
    tick();
    bus.p_req  = 1'b1;
    bus.p_addr = 12'h010;
    for (int b = 1; b < 16; b++) begin
      bus.l_addr  = 12'h100 + 12'(b);
      bus.l_wdata = 32'(b);
      #1;
      check_eq($sformatf("burst_beat_%0d", b), {bus.p_gnt, bus.l_gnt}, 2'b01);
      tick();
    end
    bus.l_addr  = 12'h110;
    bus.l_wdata = 32'd16;
    #1;
    check_eq("lock_exit_p", {bus.p_gnt, bus.l_gnt}, 2'b10);
    tick();
    bus.p_req = 1'b0;
    #1;
    check_eq("loader_resume", {bus.p_gnt, bus.l_gnt}, 2'b01);
    tick();
    clear_inputs();
    tick();
    bus.l_req  = 1'b1;
    bus.l_addr = 12'h10F;
    tick();
    clear_inputs();
    #1;
    check_eq("burst_mem_rvalid", {bus.p_rvalid, bus.l_rvalid}, 2'b01);
    check_eq("burst_mem_15", bus.rdata, 32'd15);
    tick();
    bus.l_req  = 1'b1;
    bus.l_addr = 12'h110;
    tick();
    clear_inputs();
    #1;
    check_eq("burst_mem_16", bus.rdata, 32'd16);
    tick();

    // Idle hold after a write
    bus.p_req   = 1'b1;
    bus.p_wren  = 1'b1;
    bus.p_addr  = 12'h055;
    bus.p_wdata = 32'hA5A50001;
    #1;
    check_eq("hold_wren_on", bus.wren, 1'b1);
    tick();
    clear_inputs();
    #1;
    check_eq("hold_wren_off", bus.wren, 1'b0);
    check_eq("hold_addr", bus.address_dmem, 12'h055);
    check_eq("hold_data", bus.data, 32'hA5A50001);
    tick();

    // Reset during a locked read burst
    bus.l_req  = 1'b1;
    bus.l_lock = 1'b1;
    bus.l_addr = 12'h010;
    tick();
    bus.l_addr = 12'h001;
    #1;
    check_eq("midrst_lock_gnt", {bus.p_gnt, bus.l_gnt}, 2'b01);
    tick();
    reset = 1'b1;
    #1;
    check_eq("midrst_rvalid", {bus.p_rvalid, bus.l_rvalid}, 2'b00);
    tick();
    reset = 1'b0;
    clear_inputs();
    bus.p_req = 1'b1;
    bus.l_req = 1'b1;
    #1;
    check_eq("postrst_rvalid", {bus.p_rvalid, bus.l_rvalid}, 2'b00);
    check_eq("postrst_conflict", {bus.p_gnt, bus.l_gnt}, 2'b10);
    tick();
    clear_inputs();
    tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/dmem_arbiter.md
# dmem_arbiter

Arbitrates the single-port synchronous `dmem` between two requesters: the `processor` data port and a loader/debug master that preloads or inspects data memory. It sits between those masters and `my_dmem` on the shared `clock`. It issues per-cycle grants, supports locked loader bursts, bounds starvation, and routes the one-cycle-latency read data back to whichever requester issued the read.

## Interface
Parameters:
- `ADDR_W`, 12: dmem word-address width.
- `DATA_W`, 32: data width.
- `MAX_WAIT`, 4: consecutive denied loader cycles before a forced loader grant (fixed-priority mode only).
- `MAX_BURST`, 16: maximum beats in one locked loader burst.

Ports:
- `clock`  in  1: the single clock; all state updates on its rising edge.
- `reset`  in  1: synchronous, active-high.
- `p_req`  in  1: processor access request.
- `p_wren`  in  1: processor write when 1, read when 0.
- `p_addr`  in  ADDR_W: processor address.
- `p_wdata`  in  DATA_W: processor write data.
- `p_gnt`  out  1: processor access accepted this cycle.
- `p_rvalid`  out  1: processor read data valid.
- `l_req`, `l_wren`, `l_addr`, `l_wdata`, `l_gnt`, `l_rvalid`: loader equivalents of the processor signals above.
- `l_lock`  in  1: request that the loader keep ownership after this beat.
- `rdata`  out  DATA_W: read data, shared by both requesters and qualified by the `*_rvalid` signals.
- `address_dmem`  out  ADDR_W: to dmem.
- `data`  out  DATA_W: to dmem.
- `wren`  out  1: to dmem.
- `q_dmem`  in  DATA_W: from dmem.

## Operation
State machine:
- **IDLE**: arbitrate each cycle.
  - Only one request present: grant it.
  - Both requesting: apply the policy in Configuration.
  - Loader granted with `l_lock`=1 and `MAX_BURST`>1: go to LOCK_L and set `burst_cnt`=1.
- **LOCK_L**: the loader owns dmem and `p_gnt`=0.
  - `l_req`=1: `l_gnt`=1 and `burst_cnt` increments.
  - Return to IDLE when:
    - a granted beat has `l_lock`=0;
    - `l_req`=0 (the burst is abandoned); or
    - `burst_cnt` reaches `MAX_BURST` (the final beat is granted, then the lock expires).
  - After any exit, the next IDLE cycle prefers the processor if it is requesting, in both modes.

Grant and handshake rules:
- Grants are mutually exclusive; `p_gnt & l_gnt` never equals 1.
- A requester that is not granted holds `req` and its payload stable until granted. The processor stalls on `!p_gnt`.

dmem drive:
- `address_dmem`, `data` and `wren` are muxed combinationally from the granted requester.
- With no grant: `wren`=0, and `address_dmem` and `data` keep their last granted values, held in registers.

Read return:
- A granted read (`wren`=0) at cycle N loads a registered owner tag.
- At N+1: `rdata`=`q_dmem`, and exactly one of `p_rvalid`/`l_rvalid` is 1.
- Writes produce no `rvalid`.
- Back-to-back reads from alternating owners return in order, one per cycle.

Reset, while asserted and at the first edge:
- State is IDLE; `burst_cnt`, `wait_cnt` and the owner tag are 0.
- Both `rvalid` outputs are 0, `p_gnt`=`l_gnt`=0, `wren`=0, and `address_dmem`=`data`=0.
- Reset mid-burst or mid-read drops the lock and any pending `rvalid`.

## Timing
- Grant is combinational from the current state and the requests: zero-cycle acceptance.
- Read latency is 1 cycle from the grant to `rvalid`.
- Write commit happens at the grant edge.
- Locked-burst throughput is 1 beat per cycle.
- Lock exit to processor grant takes 1 cycle when the processor was waiting.

## Configuration
- `DMEM_ARB_RR_EN` defined (round robin):
  - On conflict in IDLE, grant the requester not granted last.
  - A `last_winner` register resets to loader, so the processor wins the first conflict.
  - `wait_cnt` is not built.
- `DMEM_ARB_RR_EN` undefined (fixed priority):
  - On conflict the processor wins.
  - `wait_cnt` counts consecutive cycles with `l_req`=1 and `l_gnt`=0, saturating at `MAX_WAIT`.
  - When `wait_cnt`=`MAX_WAIT`, the loader is granted despite `p_req`; `wait_cnt` clears on any loader grant.

## Structure
- Package `dmem_arb_pkg` holds:
  - the state enum (IDLE, LOCK_L);
  - the owner encoding (OWN_P=0, OWN_L=1);
  - default `ADDR_W`/`DATA_W` constants.
- Sub-module `sat_counter` (width, limit; inc/clr; outputs count and at_limit) is instantiated for `burst_cnt` and, in fixed-priority mode, for `wait_cnt`.

## Test plan
- **Read return**: processor-only read at 0x010, where dmem holds 0xDEADBEEF → `p_gnt`=1 same cycle; next cycle `p_rvalid`=1, `rdata`=0xDEADBEEF, `l_rvalid`=0.
- **Sustained conflict, fixed priority**: both requesting continuously, `MAX_WAIT`=4, macro off → `p_gnt` for 4 cycles, `l_gnt` on the 5th, then the pattern repeats. With the macro on → grants alternate P,L,P,L.
- **Locked burst**: loader burst of 20 writes with `l_lock`=1, `MAX_BURST`=16, processor requesting → `l_gnt` for 16 consecutive cycles and `p_gnt`=0 throughout. Cycle 17 is `p_gnt`=1 and the loader resumes after.
- **Alternating reads**: reads P@0x001, L@0x002, P@0x003 on consecutive cycles → `rvalid` sequence P,L,P with the matching `q_dmem` data, no bubbles.
- **Reset mid-operation**: reset asserted during LOCK_L with a read pending → next cycle both `rvalid`=0 and the FSM is in IDLE. The first conflict after reset goes to the processor.
- **Idle hold**: write then idle → `wren`=0 while `address_dmem` and `data` hold the last written values.
